// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: FIFO-buffered words shifted out one bit per clock
// on x_out, with gapless back-to-back framing when the FIFO has data ready.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             din,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic                         x_out,
  output logic                         x_valid,
  output logic                         frame_start,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int BCW  = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [BCW-1:0]    bitcnt_q, bitcnt_d;
  logic              push, pop, last_bit, fifo_nonempty;

  // Ready comes from the registered count only, so a full FIFO refuses even on a pop cycle.
  assign din_ready     = (count_q < CNTW'(DEPTH));
  assign push          = din_valid && din_ready;
  assign fifo_nonempty = (count_q != '0);
  assign last_bit      = (bitcnt_q == BCW'(WIDTH-1));
  assign pop           = fifo_nonempty && ((state_q == S_IDLE) || last_bit);

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          sh_d     = mem_q[rd_ptr_q];
          bitcnt_d = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          bitcnt_d = '0;
          if (pop) begin
            sh_d = mem_q[rd_ptr_q];
          end else begin
            sh_d    = '0;
            state_d = S_IDLE;
          end
        end else begin
          bitcnt_d = bitcnt_q + BCW'(1);
          sh_d     = (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      bitcnt_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign x_valid     = (state_q == S_SHIFT);
  assign x_out       = x_valid ? ((MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
  assign frame_start = x_valid && (bitcnt_q == '0);
  assign busy        = x_valid || fifo_nonempty;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized scoreboard bench for piso_serializer: accepted words are expanded into
// expected serial bits and checked against x_out/frame_start as they appear.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din, din1;
  logic       din_valid, din_valid1;
  logic       din_ready, x_out, x_valid, frame_start, busy;
  logic       din_ready1, x_out1, x_valid1, frame_start1, busy1;
  logic [2:0] fifo_count, fifo_count1;

  int checks = 0;
  int errors = 0;

  typedef struct {logic b; logic first;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int run_len = 0;
  int last_run = 0;
  int valid_seen = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .x_out(x_out), .x_valid(x_valid), .frame_start(frame_start), .busy(busy),
    .fifo_count(fifo_count)
  );

  piso_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1), .din_ready(din_ready1),
    .x_out(x_out1), .x_valid(x_valid1), .frame_start(frame_start1), .busy(busy1),
    .fifo_count(fifo_count1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: word w yields bits w[7]..w[0], the first flagged as frame start.
  task automatic model_push(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.b     = ((w >> (7 - i)) & 8'd1) != 0;
      e.first = (i == 0);
      sbq.push_back(e);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  // Caller sits at a negedge; on return the word has been taken at the following posedge.
  task automatic send(input logic [7:0] w);
    int g = 0;
    din = w;
    din_valid = 1'b1;
    while (!din_ready && g < 200) begin
      nclk();
      g++;
    end
    chk("send_timeout", (g < 200), 1);
    if (din_ready) model_push(w);
    nclk();
    din_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sbq.size() != 0 || x_valid) && g < 500) begin
      nclk();
      g++;
    end
    chk("drain_timeout", (g < 500), 1);
    nclk();
  endtask

  always @(negedge clk) begin
    if (rst && x_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bit: got x_valid=1 x_out=%0b expected no data at %0t", x_out, $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("x_out", x_out, mon_e.b);
        chk("frame_start", frame_start, mon_e.first);
      end
    end
  end

  always @(negedge clk) begin
    if (x_valid) begin
      run_len++;
      valid_seen++;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cur, w;
    int accepted;
    bit seen_full, seen_reopen;

    rst = 1'b0; din = '0; din_valid = 1'b0; din1 = '0; din_valid1 = 1'b0;
    repeat (3) nclk();
    chk("rst_x_out", x_out, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_start", frame_start, 0);
    rst = 1'b1;
    nclk();

    // Single word: latency and idle return
    din = 8'hA5; din_valid = 1'b1;
    if (din_ready) model_push(8'hA5);
    nclk();
    din_valid = 1'b0;
    chk("lat_e_plus0_valid", x_valid, 0);
    chk("lat_e_plus0_count", fifo_count, 1);
    nclk();
    chk("lat_first_valid", x_valid, 1);
    chk("lat_first_frame", frame_start, 1);
    wait_drain();
    chk("a5_run_len", last_run, 8);
    chk("a5_idle_valid", x_valid, 0);
    chk("a5_idle_x_out", x_out, 0);
    chk("a5_idle_busy", busy, 0);

    // Back-to-back words form one contiguous stream
    send(8'h02); send(8'hC0); send(8'hFF);
    wait_drain();
    chk("b2b_run_len", last_run, 24);

    // Sustained valid: fill to full, then refill without loss
    accepted = 0; seen_full = 0; seen_reopen = 0;
    cur = 8'($urandom);
    din = cur; din_valid = 1'b1;
    for (int c = 0; c < 300 && accepted < 8; c++) begin
      if (din_ready) begin
        if (seen_full && !seen_reopen) begin
          seen_reopen = 1;
          chk("reopen_count", fifo_count, 3);
        end
        model_push(cur);
        accepted++;
        nclk();
        cur = cur + 8'd1 + 8'($urandom_range(0, 100));
        din = cur;
      end else begin
        if (!seen_full) begin
          seen_full = 1;
          chk("full_accepted", accepted, 5);
          chk("full_count", fifo_count, 4);
          chk("full_busy", busy, 1);
        end
        nclk();
      end
    end
    din_valid = 1'b0;
    chk("full_seen", seen_full, 1);
    chk("full_accepted_total", accepted, 8);
    wait_drain();

    // Async reset mid-word with two words queued
    send(8'h5A);
    send(8'($urandom));
    send(8'($urandom));
    nclk(); nclk();
    chk("mid_valid_before_rst", x_valid, 1);
    chk("mid_queued", fifo_count, 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_x_valid", x_valid, 0);
    chk("arst_x_out", x_out, 0);
    chk("arst_frame_start", frame_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_din_ready", din_ready, 1);
    sbq.delete();
    repeat (2) nclk();
    rst = 1'b1;
    valid_seen = 0;
    repeat (40) nclk();
    chk("post_rst_no_output", valid_seen, 0);
    run_len = 0;

    // Random words with random gaps
    for (int k = 0; k < 20; k++) begin
      send(8'($urandom));
      repeat ($urandom_range(0, 12)) nclk();
    end
    wait_drain();
    chk("random_sb_empty", sbq.size(), 0);

    // LSB-first instance
    for (int t = 0; t < 2; t++) begin
      int g = 0;
      w = (t == 0) ? 8'h01 : 8'($urandom);
      din1 = w; din_valid1 = 1'b1;
      nclk();
      din_valid1 = 1'b0;
      while (!x_valid1 && g < 50) begin
        nclk();
        g++;
      end
      chk("lsb_start_timeout", (g < 50), 1);
      for (int i = 0; i < 8; i++) begin
        chk("lsb_x_valid", x_valid1, 1);
        chk("lsb_x_out", x_out1, ((w >> i) & 8'd1));
        chk("lsb_frame_start", frame_start1, (i == 0));
        nclk();
      end
      chk("lsb_idle", x_valid1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
